conv_mac_engine: RTL and testbench
==================================

// Module: conv_mac_engine
// PURPOSE
//   Sequential multiply-accumulate core of the convolution accelerator. Sits downstream of the
//   wishbone register file in the accelerator top (top_wb_1), which loads the operands.
//   On a start pulse it captures one TAPS-point window (unsigned pixels, signed weights) plus
//   a bias, and accumulates one tap per cycle. It returns the result, optionally ReLU-clipped,
//   over a valid/ready handshake.
// PARAMETERS
//   DW    8   pixel width, unsigned
//   WW    8   weight width, two's complement
//   TAPS  9   taps per window (3x3 kernel)
//   AW    32  accumulator/result width; must satisfy AW >= DW+WW+1+$clog2(TAPS)
// PORTS
//   clk          in   1        system clock (wishbone clock)
//   rst          in   1        asynchronous reset, active-high
//   start_i      in   1        request a new window; sampled only in IDLE
//   data_i       in   TAPS*DW  pixels; tap k = data_i[k*DW +: DW]
//   weight_i     in   TAPS*WW  weights; tap k = weight_i[k*WW +: WW]
//   bias_i       in   AW       signed bias; initial accumulator value
//   relu_en_i    in   1        1: a negative result is replaced by 0
//   res_o        out  AW       signed result; valid while res_valid_o=1
//   res_valid_o  out  1        result available
//   res_ready_i  in   1        consumer accepts the result
//   busy_o       out  1        state != IDLE
//   done_o       out  1        one-cycle pulse when a result is consumed
//   state_o      out  2        IDLE=0, MAC=1, OUT=2 (drives the debug/LA flags)
// BEHAVIOUR
// - Reset (async, any state): state=IDLE, tap index=0, accumulator=0, and all outputs=0.
//   Captured operands are cleared.
// - IDLE: on an edge with start_i=1:
//   - capture data_i, weight_i and relu_en_i into internal registers;
//   - acc <= sign-extended bias_i; idx <= 0; go to MAC.
//   Inputs may change freely after the capture edge.
// - MAC: each edge computes prod = $signed({1'b0,pix[idx]}) * $signed(wgt[idx]) (DW+WW+1 bits),
//   sign-extends it to AW bits and adds it to acc.
//   - idx < TAPS-1: acc <= acc+prod; idx <= idx+1.
//   - idx == TAPS-1: res_o <= relu(acc+prod); res_valid_o <= 1; go to OUT.
// - Latency: res_valid_o rises TAPS edges after the start capture edge.
//   With TAPS=9, start is captured at E0 and the result is valid after E9.
// - OUT: res_o and res_valid_o are held stable while res_ready_i=0.
//   On an edge with res_valid_o & res_ready_i: res_valid_o <= 0, done_o <= 1 for one cycle,
//   go to IDLE.
// - start_i is ignored in MAC and OUT. It is not queued.
//   start_i held high gives one result per TAPS+2 cycles when res_ready_i=1.
// - Arithmetic: two's-complement addition modulo 2^AW, with no saturation.
//   relu: the MSB of the result=1 -> 0. res_o is never X after reset.
// - res_ready_i asserted while not in OUT has no effect.
// - done_o and res_valid_o are never high in the same cycle.
// TESTING
// 1. data=1, weight=1 (all taps), bias=0, relu=0, ready=1 -> res_o=9 valid after 9 edges;
//    done pulses once.
// 2. data=255, weight=-128 (all taps), bias=0 -> res_o=32'hFFFB_8480 (-293760).
//    Same with relu_en=1 -> res_o=0.
// 3. Tap order: pixel k=k+1, weight k=k-4, bias=100 -> res_o=160.
//    Swapping taps 0 and 8 in both the pixel and weight vectors gives the same result.
// 4. Back-pressure: ready=0 for 20 cycles -> res_o stable, valid=1, busy=1.
//    Start pulses are ignored. Then ready=1 -> done pulse and IDLE on the next edge.
// 5. Reset asserted asynchronously during the MAC phase (idx=4) -> all outputs 0 at once,
//    state_o=0. The next start reproduces test 1 exactly.
// 6. start held high with ready=1 for 50 cycles -> a result every 11 cycles;
//    bias=-5 with all weights 0 -> res_o=-5; with relu_en=1 -> res_o=0.

Source files
------------

// File: rtl/conv_mac_engine_if.sv
// conv_mac_engine_if: operand/start inputs and result handshake of the MAC engine; master drives operands, slave is the engine
interface conv_mac_engine_if #(
  parameter int DW   = 8,
  parameter int WW   = 8,
  parameter int TAPS = 9,
  parameter int AW   = 32
);
  logic                 start_i;
  logic [TAPS*DW-1:0]   data_i;
  logic [TAPS*WW-1:0]   weight_i;
  logic [AW-1:0]        bias_i;
  logic                 relu_en_i;
  logic [AW-1:0]        res_o;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic                 busy_o;
  logic                 done_o;
  logic [1:0]           state_o;
  modport master (
    output start_i, data_i, weight_i, bias_i, relu_en_i, res_ready_i,
    input  res_o, res_valid_o, busy_o, done_o, state_o
  );
  modport slave (
    input  start_i, data_i, weight_i, bias_i, relu_en_i, res_ready_i,
    output res_o, res_valid_o, busy_o, done_o, state_o
  );
endinterface

// File: rtl/conv_mac_engine.sv
// conv_mac_engine: one-tap-per-cycle MAC over a captured window with optional ReLU; ports clk, rst (async high), bus (slave: start/operands in, result valid/ready out, busy/done/state status)
module conv_mac_engine #(
  parameter int DW   = 8,
  parameter int WW   = 8,
  parameter int TAPS = 9,
  parameter int AW   = 32,
  localparam int IW  = (TAPS > 1) ? $clog2(TAPS) : 1
) (
  input logic              clk,
  input logic              rst,
  conv_mac_engine_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;
  localparam logic [IW-1:0] LAST = IW'(TAPS - 1);
  logic [1:0]         r_state;
  logic [IW-1:0]      r_idx;
  logic [AW-1:0]      r_acc;
  logic [TAPS*DW-1:0] r_pix;
  logic [TAPS*WW-1:0] r_wgt;
  logic               r_relu;
  logic [AW-1:0]      r_res;
  logic               r_valid;
  logic               r_done;
  logic [DW-1:0]        w_pix;
  logic signed [WW-1:0] w_wgt;
  logic signed [DW+WW:0] w_prod;
  logic [AW-1:0]        w_sum;
  logic [AW-1:0]        w_out;
  assign w_pix  = r_pix[r_idx*DW +: DW];
  assign w_wgt  = r_wgt[r_idx*WW +: WW];
  // pixel is zero-extended to stay unsigned inside a signed multiply
  assign w_prod = $signed({1'b0, w_pix}) * w_wgt;
  assign w_sum  = r_acc + {{(AW-DW-WW-1){w_prod[DW+WW]}}, w_prod};
  assign w_out  = (r_relu && w_sum[AW-1]) ? '0 : w_sum;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_acc   <= '0;
      r_pix   <= '0;
      r_wgt   <= '0;
      r_relu  <= 1'b0;
      r_res   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_IDLE && bus.start_i) begin
        r_pix   <= bus.data_i;
        r_wgt   <= bus.weight_i;
        r_relu  <= bus.relu_en_i;
        r_acc   <= bus.bias_i;
        r_idx   <= '0;
        r_state <= S_MAC;
      end else if (r_state == S_MAC) begin
        if (r_idx == LAST) begin
          r_res   <= w_out;
          r_valid <= 1'b1;
          r_state <= S_OUT;
        end else begin
          r_acc <= w_sum;
          r_idx <= r_idx + 1'b1;
        end
      end else if (r_state == S_OUT && bus.res_ready_i) begin
        r_valid <= 1'b0;
        r_done  <= 1'b1;
        r_state <= S_IDLE;
      end
    end
  end
  assign bus.res_o       = r_res;
  assign bus.res_valid_o = r_valid;
  assign bus.busy_o      = r_state != S_IDLE;
  assign bus.done_o      = r_done;
  assign bus.state_o     = r_state;
endmodule

// File: tb/tb_conv_mac_engine.sv
// tb_conv_mac_engine: table-driven vectors plus back-pressure, async reset and held-start sequences, scored through a result queue
module tb_conv_mac_engine;
  localparam int DW = 8, WW = 8, TAPS = 9, AW = 32, NV = 12;
  typedef struct {
    logic [TAPS*DW-1:0] d;
    logic [TAPS*WW-1:0] w;
    logic [AW-1:0]      b;
    logic               r;
    logic [AW-1:0]      e;
    string              n;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [AW-1:0] q[$];
  vec_t tv[NV];
  always #5 clk = ~clk;
  conv_mac_engine_if #(.DW(DW), .WW(WW), .TAPS(TAPS), .AW(AW)) bus();
  conv_mac_engine #(.DW(DW), .WW(WW), .TAPS(TAPS), .AW(AW)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string n, input logic [AW-1:0] a, input logic [AW-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask
  function automatic logic [AW-1:0] model(input logic [TAPS*DW-1:0] d, input logic [TAPS*WW-1:0] w,
                                          input logic [AW-1:0] b, input logic r);
    int acc = int'(b);
    for (int k = 0; k < TAPS; k++) begin
      logic signed [WW-1:0] wk = w[k*WW +: WW];
      acc += int'({1'b0, d[k*DW +: DW]}) * int'(wk);
    end
    return (r && acc < 0) ? '0 : AW'(acc);
  endfunction
  always @(negedge clk) begin
    if (!rst) begin
      chk("done_valid_exclusive", AW'(bus.done_o & bus.res_valid_o), '0);
      if (bus.res_valid_o && bus.res_ready_i) begin
        if (q.size() == 0) chk("unexpected_result", bus.res_o, 'x);
        else chk("result", bus.res_o, q.pop_front());
      end
    end
  end
  task automatic drive(input vec_t t, input logic rdy);
    bus.data_i      = t.d;
    bus.weight_i    = t.w;
    bus.bias_i      = t.b;
    bus.relu_en_i   = t.r;
    bus.res_ready_i = rdy;
    bus.start_i     = 1'b1;
    q.push_back(t.e);
    @(posedge clk); #1;
    bus.start_i   = 1'b0;
    bus.data_i    = {8'($urandom), $urandom, $urandom};
    bus.weight_i  = {8'($urandom), $urandom, $urandom};
    bus.bias_i    = $urandom;
    bus.relu_en_i = ~t.r;
  endtask
  task automatic wait_valid(input string n);
    int c = 0;
    while (!bus.res_valid_o && c < 40) begin
      @(posedge clk); #1;
      c++;
    end
    chk({n, "_latency"}, AW'(c), AW'(TAPS));
  endtask
  task automatic run_window(input vec_t t);
    drive(t, 1'b1);
    wait_valid(t.n);
    @(posedge clk); #1;
    chk({t.n, "_done"}, AW'(bus.done_o), 1);
    chk({t.n, "_idle"}, AW'(bus.state_o), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    logic [TAPS*DW-1:0] p3, p3s, rd;
    logic [TAPS*WW-1:0] w3, w3s;
    logic [AW-1:0] hold;
    int cyc, last, cnt;
    for (int k = 0; k < TAPS; k++) begin
      p3[k*DW +: DW] = DW'(k + 1);
      w3[k*WW +: WW] = WW'(k - 4);
    end
    p3s = p3;
    w3s = w3;
    p3s[0 +: DW] = p3[(TAPS-1)*DW +: DW];
    p3s[(TAPS-1)*DW +: DW] = p3[0 +: DW];
    w3s[0 +: WW] = w3[(TAPS-1)*WW +: WW];
    w3s[(TAPS-1)*WW +: WW] = w3[0 +: WW];
    rd = {8'($urandom), $urandom, $urandom};
    tv[0]  = '{{TAPS{8'd1}},   {TAPS{8'd1}},   32'd0,   1'b0, 32'd9,         "ones"};
    tv[1]  = '{{TAPS{8'd255}}, {TAPS{8'h80}},  32'd0,   1'b0, 32'hFFFB_8480, "maxneg"};
    tv[2]  = '{{TAPS{8'd255}}, {TAPS{8'h80}},  32'd0,   1'b1, 32'd0,         "maxneg_relu"};
    tv[3]  = '{p3,  w3,  32'd100, 1'b0, 32'd160, "tap_order"};
    tv[4]  = '{p3s, w3s, 32'd100, 1'b0, 32'd160, "tap_swap"};
    tv[5]  = '{rd, '0, 32'hFFFF_FFFB, 1'b0, 32'hFFFF_FFFB, "bias_only"};
    tv[6]  = '{rd, '0, 32'hFFFF_FFFB, 1'b1, 32'd0,         "bias_only_relu"};
    tv[7]  = '{{TAPS{8'd1}}, {TAPS{8'd1}}, 32'h7FFF_FFFF, 1'b0, 32'h8000_0008, "wrap"};
    tv[8]  = '{{TAPS{8'd1}}, {TAPS{8'd1}}, 32'h7FFF_FFFF, 1'b1, 32'd0,         "wrap_relu"};
    for (int i = 9; i < NV; i++) begin
      tv[i].d = {8'($urandom), $urandom, $urandom};
      tv[i].w = {8'($urandom), $urandom, $urandom};
      tv[i].b = 32'($signed(16'($urandom)));
      tv[i].r = 1'(i);
      tv[i].e = model(tv[i].d, tv[i].w, tv[i].b, tv[i].r);
      tv[i].n = $sformatf("rand%0d", i);
    end
    bus.start_i = 1'b0; bus.data_i = '0; bus.weight_i = '0; bus.bias_i = '0;
    bus.relu_en_i = 1'b0; bus.res_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_res", bus.res_o, 0);
    chk("rst_valid", AW'(bus.res_valid_o), 0);
    chk("rst_busy", AW'(bus.busy_o), 0);
    chk("rst_done", AW'(bus.done_o), 0);
    chk("rst_state", AW'(bus.state_o), 0);
    rst = 1'b0;
    for (int i = 0; i < NV; i++) run_window(tv[i]);
    drive(tv[3], 1'b0);
    wait_valid("bp");
    hold = bus.res_o;
    for (int i = 0; i < 20; i++) begin
      chk("bp_res", bus.res_o, hold);
      chk("bp_valid", AW'(bus.res_valid_o), 1);
      chk("bp_busy", AW'(bus.busy_o), 1);
      chk("bp_state", AW'(bus.state_o), 2);
      bus.start_i = 1'(i);
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0;
    chk("bp_queue", AW'(q.size()), 1);
    bus.res_ready_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_done", AW'(bus.done_o), 1);
    chk("bp_idle", AW'(bus.state_o), 0);
    @(posedge clk); #1;
    chk("bp_no_queued_start", AW'(bus.state_o), 0);
    drive(tv[0], 1'b1);
    repeat (4) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_res", bus.res_o, 0);
    chk("arst_valid", AW'(bus.res_valid_o), 0);
    chk("arst_busy", AW'(bus.busy_o), 0);
    chk("arst_state", AW'(bus.state_o), 0);
    q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    run_window(tv[0]);
    bus.data_i = rd; bus.weight_i = '0; bus.bias_i = 32'hFFFF_FFFB; bus.relu_en_i = 1'b0;
    bus.res_ready_i = 1'b1;
    repeat (4) q.push_back(32'hFFFF_FFFB);
    bus.start_i = 1'b1;
    cyc = 0; last = 0; cnt = 0;
    while (cnt < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.done_o) begin
        if (cnt > 0) chk("held_period", AW'(cyc - last), AW'(TAPS + 2));
        last = cyc;
        cnt++;
      end
    end
    bus.start_i = 1'b0;
    chk("held_count", AW'(cnt), 4);
    @(posedge clk); #1;
    chk("held_stop", AW'(bus.busy_o), 0);
    chk("queue_drained", AW'(q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
